// File: rtl/booth_error_accumulator.sv
// Error-distance statistics for the 8x8 signed Booth multiplier.
// One campaign per start pulse: count, error count, ED sum and ED max.
module booth_error_accumulator #(
  parameter int NUM_SAMPLES = 65536,
  parameter int SUM_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  input  logic [15:0]      in_p,
  output logic             busy,
  output logic             done,
  output logic [16:0]      sample_cnt,
  output logic [16:0]      err_cnt,
  output logic [SUM_W-1:0] ed_sum,
  output logic [16:0]      ed_max,
  output logic             sum_sat
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [16:0] LAST = 17'(NUM_SAMPLES);

  state_t state;
  state_t state_nx;

  logic signed [16:0] xs;
  logic signed [16:0] ys;
  logic signed [16:0] exact;
  logic signed [16:0] diff;
  logic [16:0]        ed;
  logic [16:0]        s1_ed;
  logic               s1_valid;
  logic               accept;
  logic               clear;
  logic               last_acc;
  logic [SUM_W:0]     ed_ext;
  logic [SUM_W:0]     sum_add;

  assign xs    = {{9{in_x[7]}}, in_x};
  assign ys    = {{9{in_y[7]}}, in_y};
  assign exact = xs * ys;
  assign diff  = {in_p[15], in_p} - exact;
  assign ed    = diff[16] ? (~diff + 17'd1) : diff;

  assign accept   = (state == RUN) && in_valid;
  assign clear    = start && ((state == IDLE) || (state == DONE));
  assign last_acc = accept && (sample_cnt == LAST - 17'd1);

  // One extra bit catches the carry that signals saturation
  assign ed_ext  = (SUM_W+1)'(s1_ed);
  assign sum_add = {1'b0, ed_sum} + ed_ext;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_acc) state_nx = DRAIN;
      DRAIN:   if (!s1_valid) state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_ed      <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
      sum_sat    <= 1'b0;
    end else if (clear) begin
      s1_valid   <= 1'b0;
      s1_ed      <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
      sum_sat    <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ed      <= ed;
        sample_cnt <= sample_cnt + 17'd1;
      end
      if (s1_valid) begin
        err_cnt <= err_cnt + {16'd0, |s1_ed};
        if (sum_add[SUM_W]) begin
          ed_sum  <= '1;
          sum_sat <= 1'b1;
        end else begin
          ed_sum <= sum_add[SUM_W-1:0];
        end
        if (s1_ed > ed_max) ed_max <= s1_ed;
      end
    end
  end

endmodule
